// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling 8N1 UART receiver feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 27,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            QClk,
    input  logic                            RstQnnnH,
    input  logic                            UartRxSerial,
    input  logic                            RxPopQ,
    input  logic                            ErrClearQ,
    output logic [7:0]                      RxDataQ,
    output logic                            RxValidQ,
    output logic [$clog2(FIFO_DEPTH):0]     RxCountQ,
    output logic                            RxOverrunQ,
    output logic                            RxFrameErrQ,
    output logic                            RxIrqQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [15:0]     div_q, div_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   count_q;
    logic            ovr_q, frm_q;
    logic            line, tick, stop_smp, full, push, pop_ok;

    assign line     = sync2_q;
    assign tick     = div_q == 16'(BAUD_DIV - 1);
    assign full     = count_q == CW'(FIFO_DEPTH);
    assign pop_ok   = RxPopQ && RxValidQ;
    // A full FIFO still accepts a byte when the same cycle pops, since a slot frees up
    assign push     = stop_smp && line && (!full || RxPopQ);

    assign RxValidQ    = count_q != '0;
    assign RxDataQ     = RxValidQ ? mem_q[rd_q] : 8'h00;
    assign RxCountQ    = count_q;
    assign RxOverrunQ  = ovr_q;
    assign RxFrameErrQ = frm_q;
    assign RxIrqQ      = RxValidQ || ovr_q || frm_q;

    // Deframing FSM next state plus baud divider, sample counter and shift register
    always_comb begin
        state_d  = state_q;
        div_d    = tick ? 16'd0 : div_q + 16'd1;
        cnt_d    = tick ? cnt_q + 4'd1 : cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        stop_smp = 1'b0;
        case (state_q)
            IDLE: if (!line) begin
                state_d = START;
                div_d   = 16'd0;
            end
            START: if (tick && cnt_q == 4'd7) begin
                state_d = line ? IDLE : DATA;
                idx_d   = 3'd0;
            end
            DATA: if (tick && cnt_q == 4'd15) begin
                shreg_d = {line, shreg_q[7:1]};
                idx_d   = idx_q + 3'd1;
                state_d = idx_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick && cnt_q == 4'd15) begin
                stop_smp = 1'b1;
                state_d  = line ? IDLE : BREAK;
            end
            BREAK: if (line) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = 4'd0;
    end

    // Receiver state, synchroniser, FIFO pointers and sticky flags
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            div_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            frm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= UartRxSerial;
            sync2_q <= sync1_q;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            wr_q    <= push ? wr_q + AW'(1) : wr_q;
            rd_q    <= pop_ok ? rd_q + AW'(1) : rd_q;
            count_q <= count_q + CW'(push) - CW'(pop_ok);
            ovr_q   <= (stop_smp && line && full && !RxPopQ) || (ovr_q && !ErrClearQ);
            frm_q   <= (stop_smp && !line) || (frm_q && !ErrClearQ);
        end
    end

    // FIFO storage needs no reset; the count masks stale entries
    always_ff @(posedge QClk) begin
        if (push) mem_q[wr_q] <= shreg_q;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial UART receiver with a byte FIFO, feeding the UART I/O agent of the UART tile. It oversamples the external serial input at 16x and deframes 8N1 characters. Received bytes are buffered in a first-word-fall-through FIFO that the I/O agent drains with a pop strobe. It also produces the sticky error flags and the level interrupt the tile exports.

## Interface
- BAUD_DIV, 27: QClk cycles per 1/16-bit oversample tick; legal range 1..65535.
- FIFO_DEPTH, 8: FIFO entries; must be a power of two, at least 2.
- QClk  in  1  tile clock; all state on its rising edge.
- RstQnnnH  in  1  reset; asynchronous, active-low.
- UartRxSerial  in  1  asynchronous serial line; idle high.
- RxPopQ  in  1  pop the head entry; ignored when the FIFO is empty.
- ErrClearQ  in  1  clears RxOverrunQ and RxFrameErrQ.
- RxDataQ  out  8  head entry of the FIFO; 8'h00 when empty.
- RxValidQ  out  1  FIFO is non-empty.
- RxCountQ  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries.
- RxOverrunQ  out  1  sticky flag: a good byte was dropped because the FIFO was full.
- RxFrameErrQ  out  1  sticky flag: the stop bit was sampled low.
- RxIrqQ  out  1  level interrupt; equals RxValidQ | RxOverrunQ | RxFrameErrQ.

## Operation
- **Synchroniser:** two flops on UartRxSerial, both reset to 1. The FSM uses only the synchronised value, called "line" below.
- **Tick generator:** 16-bit counter runs 0..BAUD_DIV-1. A tick is asserted in the cycle the counter equals BAUD_DIV-1, and the counter wraps to 0. The counter is forced to 0 when the FSM leaves IDLE.
- **Sample counter:** 4 bits, incremented on each tick, cleared on every state entry.
- **Bit index:** 3 bits.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. Reset state is IDLE.
  - IDLE: line==0 -> START.
  - START: on the 8th tick (mid start bit), sample line. 0 -> DATA with bit index 0. 1 -> IDLE (glitch rejected, nothing recorded).
  - DATA: on every 16th tick, shift line into bit[index], LSB first. After index 7 -> STOP.
  - STOP: on the 16th tick, sample line.
    - 1: push the byte if the FIFO is not full; if full, drop the byte and set RxOverrunQ. Go to IDLE.
    - 0: drop the byte, set RxFrameErrQ, go to BREAK.
  - BREAK: wait for line==1 -> IDLE.
- **FIFO:** circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH. Count is a separate register.
  - Push and pop in the same cycle on a non-empty FIFO: both happen, count unchanged.
  - When the FIFO is full, a pop in the same cycle as a push frees a slot, so the push is accepted and no overrun is flagged.
  - Push into an empty FIFO with a simultaneous pop: the pop is ignored and the push is accepted.
- **Sticky flags:** cleared by ErrClearQ. If a set and a clear happen in the same cycle, the set wins.
- **Reset values:** all outputs 0. FSM in IDLE; pointers, counters and shift register 0; synchroniser at 1. Reset mid-frame discards the partial byte and all FIFO contents.

## Timing
- Line to FSM: 2 QClk of synchroniser latency. The start edge is detected in IDLE on the cycle the synchronised line is first 0.
- Sample points:
  - start-bit check 8*BAUD_DIV cycles after START entry;
  - data bit k sampled (16*(k+1)+8)*BAUD_DIV cycles after START entry, nominally;
  - stop sample 16 ticks after the last data sample.
- Push: the byte appears on RxDataQ and RxValidQ rises the cycle after the stop-bit sample. RxCountQ and RxIrqQ update in the same cycle.
- Pop: RxDataQ shows the next entry, and RxCountQ decrements, the cycle after RxPopQ is asserted with the FIFO non-empty. No stall; one pop per cycle is allowed.
- Flags: a flag set is visible the cycle after the stop sample. ErrClearQ takes effect the next cycle.
- The next start bit may be detected in the cycle after returning to IDLE. Back-to-back frames with one stop bit are supported.

## Test plan
All scenarios use BAUD_DIV=2 (32 QClk per bit) and FIFO_DEPTH=8.
- **Single byte:** drive 0xA5 in 8N1 -> RxValidQ=1, RxDataQ=0xA5, RxCountQ=1, RxIrqQ=1. After one pop: RxValidQ=0, RxDataQ=0x00, RxIrqQ=0.
- **Glitch rejection:** a 0 pulse of 8 QClk on an idle line -> FSM returns to IDLE, RxCountQ=0, no flags. A following byte 0x3C is received correctly.
- **Framing error:** send 0x55 with the stop bit held low for 2 bit times, then idle, then 0x12.
  - RxFrameErrQ=1, 0x55 not stored.
  - 0x12 is stored as the only entry.
  - ErrClearQ clears the flag next cycle.
- **Overrun:** send 9 bytes 0x01..0x09 without popping.
  - RxCountQ=8, RxOverrunQ=1.
  - Popping 8 times returns 0x01..0x08 in order (pointer wrap exercised); 0x09 is lost.
- **Full with simultaneous push/pop:** fill the FIFO with 8 bytes, then assert RxPopQ in the exact cycle a 9th byte (0xEE) is pushed.
  - RxCountQ stays 8 and RxOverrunQ stays 0.
  - Draining yields bytes 2..8 followed by 0xEE.
- **Reset mid-operation:** assert RstQnnnH=0 asynchronously during data bit 4 with 3 bytes queued.
  - All outputs go to 0 immediately.
  - After release, the FSM is in IDLE and a fresh byte 0x7E is received correctly.
